// File: rtl/ppwm_pkg.sv
// ppwm_pkg: shared opcodes, control subcodes, compare sources and FSM states for ppwm_ex_v2
package ppwm_pkg;
  typedef enum logic [2:0] {
    CmdCtrl, CmdSet, CmdAdd, CmdShift, CmdJump, CmdCmp, CmdBranch, CmdLoop
  } cmd_e;
  localparam int unsigned CtrlNop = 0;
  localparam int unsigned CtrlWait = 1;
  localparam int unsigned CtrlHalt = 2;
  typedef enum logic [1:0] {SrcGcLo, SrcGcHi, SrcPwm, SrcR1} cmp_src_e;
  typedef enum logic [1:0] {StIdle, StExec, StWait, StHalt} state_e;
endpackage

// File: rtl/ppwm_ex_alu.sv
// ppwm_ex_alu: combinational SET/ADD/SHIFT result and CMP flag
module ppwm_ex_alu
  import ppwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 10,
  parameter int IMM_WIDTH = 5
) (
  input  cmd_e                     cmd_i,
  input  logic [IMM_WIDTH-1:0]     imm_i,
  input  logic [COUNTER_WIDTH-1:0] a_i,
  input  logic [COUNTER_WIDTH-1:0] b_i,
  output logic [COUNTER_WIDTH-1:0] res_o,
  output logic                     flag_o
);
  logic [IMM_WIDTH-1:0] amt;
  logic [COUNTER_WIDTH-1:0] shifted;
  assign amt = {1'b0, imm_i[IMM_WIDTH-1:1]} + IMM_WIDTH'(1);
  assign shifted = 32'(amt) >= COUNTER_WIDTH ? '0 : imm_i[0] ? a_i << amt : a_i >> amt;
  assign res_o = cmd_i == CmdSet ? COUNTER_WIDTH'(imm_i) :
                 cmd_i == CmdAdd ? a_i + COUNTER_WIDTH'($signed(imm_i)) :
                 cmd_i == CmdShift ? shifted : a_i;
  assign flag_o = imm_i[2] ? b_i == a_i : b_i < a_i;
endmodule

// File: rtl/ppwm_ex_v2.sv
// ppwm_ex_v2: programmable PWM execution unit; define PPWM_EX_LOOP_EN for the hardware loop counter
module ppwm_ex_v2
  import ppwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = 10,
  parameter int GLOBAL_COUNTER_WIDTH = 20,
  parameter int NUM_REGS = 3,
  parameter int INSTR_WIDTH = 10,
  parameter int PC_WIDTH = 5,
  parameter int LOOP_WIDTH = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start_i,
  input  logic [GLOBAL_COUNTER_WIDTH-1:0] global_counter_i,
  input  logic [INSTR_WIDTH-1:0]          instr_i,
  output logic [PC_WIDTH-1:0]             pc_o,
  output logic [COUNTER_WIDTH-1:0]        pwm_value_o,
  output logic                            busy_o,
  output logic                            halted_o,
  output logic                            illegal_o
);
  localparam int TW = $clog2(NUM_REGS + 1);
  localparam int IW = INSTR_WIDTH - 3 - TW;
  state_e state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, off, loff;
  logic [COUNTER_WIDTH-1:0] pwm_q, pwm_d, a, b, res;
  logic [COUNTER_WIDTH-1:0] regs_q [NUM_REGS];
  logic [COUNTER_WIDTH-1:0] regs_d [NUM_REGS];
  logic flag_q, flag_d, illegal_q, illegal_d, alu_flag, exec, bad, wr, loop_take;
  cmd_e cmd;
  cmp_src_e src;
  logic [TW-1:0] t;
  logic [IW-1:0] imm;
  assign cmd = cmd_e'(instr_i[2:0]);
  assign t = instr_i[3+TW-1:3];
  assign imm = instr_i[INSTR_WIDTH-1:3+TW];
  assign src = cmp_src_e'(imm[1:0]);
  assign off = PC_WIDTH'($signed(instr_i[INSTR_WIDTH-1:3]));
  assign exec = state_q == StExec;
`ifdef PPWM_EX_LOOP_EN
  localparam bit LoopEn = 1'b1;
  logic [LOOP_WIDTH-1:0] lc_q, lc_d;
  logic loop_op;
  assign loop_op = exec && cmd == CmdLoop;
  assign loop_take = loop_op && instr_i[3] && lc_q != '0;
  assign loff = PC_WIDTH'($signed(instr_i[INSTR_WIDTH-1:4]));
  assign lc_d = !loop_op ? lc_q : !instr_i[3] ? LOOP_WIDTH'(instr_i[INSTR_WIDTH-1:4]) :
                loop_take ? lc_q - LOOP_WIDTH'(1) : lc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lc_q <= '0;
    else lc_q <= lc_d;
`else
  localparam bit LoopEn = 1'b0;
  assign loop_take = 1'b0;
  assign loff = '0;
`endif
  always_comb begin
    a = pwm_q;
    for (int i = 0; i < NUM_REGS; i++) a = 32'(t) == i + 1 ? regs_q[i] : a;
  end
  assign b = src == SrcGcLo ? global_counter_i[COUNTER_WIDTH-1:0] :
             src == SrcGcHi ? COUNTER_WIDTH'(global_counter_i >> COUNTER_WIDTH) :
             src == SrcPwm ? pwm_q : regs_q[0];
  // an illegal word still advances pc but must leave every register untouched
  assign bad = (cmd inside {CmdSet, CmdAdd, CmdShift, CmdCmp} && 32'(t) > NUM_REGS) ||
               (cmd == CmdCtrl && 32'(imm) > CtrlHalt) || (cmd == CmdLoop && !LoopEn);
  assign wr = exec && !bad && cmd inside {CmdSet, CmdAdd, CmdShift};
  ppwm_ex_alu #(.COUNTER_WIDTH(COUNTER_WIDTH), .IMM_WIDTH(IW)) u_alu (
    .cmd_i(cmd), .imm_i(imm), .a_i(a), .b_i(b), .res_o(res), .flag_o(alu_flag)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= StIdle;
    else state_q <= state_d;
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle, StWait: state_d = start_i ? StExec : state_q;
      StHalt: state_d = start_i ? StExec : StHalt;
      StExec: state_d = cmd == CmdCtrl && 32'(imm) == CtrlWait ? StWait :
                        cmd == CmdCtrl && 32'(imm) == CtrlHalt ? StHalt :
                        &pc_q ? StIdle : StExec;
      default: state_d = StIdle;
    endcase
  end
  always_comb begin
    busy_o = state_q == StExec;
    halted_o = state_q == StHalt;
  end
  assign pc_d = exec ? (cmd == CmdJump || (cmd == CmdBranch && flag_q) ? pc_q + off :
                        loop_take ? pc_q + loff : pc_q + PC_WIDTH'(1)) :
                state_q == StHalt && start_i ? '0 : pc_q;
  assign pwm_d = wr && t == '0 ? res : pwm_q;
  always_comb
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = wr && 32'(t) == i + 1 ? res : regs_q[i];
  assign flag_d = exec && !bad && cmd == CmdCmp ? alu_flag : flag_q;
  assign illegal_d = exec && bad;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q <= '0;
      pwm_q <= '0;
      flag_q <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      pwm_q <= pwm_d;
      flag_q <= flag_d;
      illegal_q <= illegal_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  assign pc_o = pc_q;
  assign pwm_value_o = pwm_q;
  assign illegal_o = illegal_q;
endmodule

// File: tb/tb_ppwm_ex_v2.sv
// tb_ppwm_ex_v2: directed programs checked against an instruction-level model every cycle
module tb_ppwm_ex_v2;
  localparam int S_IDLE = 0, S_EXEC = 1, S_WAIT = 2, S_HALT = 3;
  typedef struct packed {
    logic [1:0] st;
    logic [4:0] pc;
    logic [9:0] pwm, r1, r2;
    logic flag, ill;
    logic [5:0] lc;
  } m_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_i = 1'b0;
  logic [19:0] global_counter_i = '0;
  logic [9:0] instr_i;
  logic [4:0] pc_o;
  logic [9:0] pwm_value_o;
  logic busy_o, halted_o, illegal_o;
  logic [9:0] mem [32];
  m_t m;
  bit run_chk = 1'b0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  assign instr_i = mem[pc_o];
  ppwm_ex_v2 #(.NUM_REGS(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .global_counter_i(global_counter_i),
    .instr_i(instr_i), .pc_o(pc_o), .pwm_value_o(pwm_value_o), .busy_o(busy_o),
    .halted_o(halted_o), .illegal_o(illegal_o)
  );
  function automatic logic [9:0] enc(int op, int t, int imm);
    return {imm[4:0], t[1:0], op[2:0]};
  endfunction
  function automatic logic [9:0] encj(int op, int off);
    return {off[6:0], op[2:0]};
  endfunction
  function automatic logic [9:0] encl(int f, int bflag);
    return {f[5:0], bflag[0], 3'd7};
  endfunction
  // one instruction of the architecture, in plain integer arithmetic
  function automatic m_t model_step(m_t cur, logic start, logic [19:0] gc, logic [9:0] ins);
    m_t n;
    int op, t, imm, off, fld, a, b, res, amt, npc;
    bit ill, wr;
    n = cur;
    n.ill = 1'b0;
    if (int'(cur.st) != S_EXEC) begin
      if (start && int'(cur.st) != S_EXEC) begin
        if (int'(cur.st) == S_HALT) n.pc = '0;
        n.st = 2'(S_EXEC);
      end
      return n;
    end
    op = int'(ins[2:0]);
    t = int'(ins[4:3]);
    imm = int'(ins[9:5]);
    off = int'(ins[9:3]);
    if (off >= 64) off -= 128;
    fld = int'(ins[9:4]);
    a = (t == 0) ? int'(cur.pwm) : (t == 1) ? int'(cur.r1) : (t == 2) ? int'(cur.r2) : 0;
    ill = (op inside {1, 2, 3, 5}) && t > 2;
    wr = 1'b0;
    res = 0;
    npc = int'(cur.pc) + 1;
    n.st = (cur.pc == 5'd31) ? 2'(S_IDLE) : 2'(S_EXEC);
    case (op)
      0: if (imm == 1) n.st = 2'(S_WAIT); else if (imm == 2) n.st = 2'(S_HALT); else if (imm > 2) ill = 1'b1;
      1: begin wr = 1'b1; res = imm; end
      2: begin wr = 1'b1; res = a + ((imm >= 16) ? imm - 32 : imm); end
      3: begin
        wr = 1'b1;
        amt = imm / 2 + 1;
        res = (amt >= 10) ? 0 : (imm % 2 == 1) ? a * (1 << amt) : a / (1 << amt);
      end
      4: npc = int'(cur.pc) + off;
      5: begin
        b = (imm % 4 == 0) ? int'(gc) % 1024 : (imm % 4 == 1) ? int'(gc) / 1024 :
            (imm % 4 == 2) ? int'(cur.pwm) : int'(cur.r1);
        if (!ill) n.flag = ((imm / 4) % 2 == 1) ? (b == a) : (b < a);
      end
      6: if (cur.flag) npc = int'(cur.pc) + off;
      default: begin
`ifdef PPWM_EX_LOOP_EN
        if (!ins[3]) n.lc = 6'(fld);
        else if (cur.lc != 0) begin
          n.lc = cur.lc - 6'd1;
          npc = int'(cur.pc) + ((fld >= 32) ? fld - 64 : fld);
        end
`else
        ill = 1'b1;
`endif
      end
    endcase
    if (wr && !ill) begin
      res = res & 1023;
      if (t == 0) n.pwm = 10'(res);
      else if (t == 1) n.r1 = 10'(res);
      else n.r2 = 10'(res);
    end
    n.pc = 5'(npc & 31);
    n.ill = ill;
    return n;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= '0;
    else m <= model_step(m, start_i, global_counter_i, mem[m.pc]);
  task automatic chk(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (run_chk) begin
      chk("pc", int'(pc_o), int'(m.pc));
      chk("pwm", int'(pwm_value_o), int'(m.pwm));
      chk("busy", int'(busy_o), int'(m.st == 2'(S_EXEC)));
      chk("halted", int'(halted_o), int'(m.st == 2'(S_HALT)));
      chk("illegal", int'(illegal_o), int'(m.ill));
    end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = '0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask
  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask
  initial begin
    clear_mem();
    #1 rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    run_chk = 1'b1;
    chk("reset_pc", int'(pc_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    // asynchronous reset in the middle of a run
    pulse_start();
    tick(5);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", int'(pc_o), 0);
    chk("async_rst_busy", int'(busy_o), 0);
    mem[0] = enc(1, 0, 5);
    mem[1] = enc(2, 0, 31);
    mem[2] = enc(3, 0, 3);
    tick(1);
    rst_n = 1'b1;
    pulse_start();
    chk("p1_busy", int'(busy_o), 1);
    chk("p1_pwm0", int'(pwm_value_o), 0);
    tick(1);
    chk("p1_set", int'(pwm_value_o), 5);
    tick(1);
    chk("p1_add", int'(pwm_value_o), 4);
    tick(1);
    chk("p1_shl", int'(pwm_value_o), 16);
    tick(28);
    chk("end_pc31", int'(pc_o), 31);
    chk("end_busy1", int'(busy_o), 1);
    tick(1);
    chk("end_pc0", int'(pc_o), 0);
    chk("end_idle", int'(busy_o), 0);
    // CMP low slice < R1, branch back while below 10
    clear_mem();
    global_counter_i = '0;
    do_reset();
    mem[0] = enc(1, 1, 10);
    mem[1] = enc(5, 1, 0);
    mem[2] = encj(6, -1);
    mem[3] = enc(1, 0, 7);
    pulse_start();
    tick(10);
    chk("loop_pc", int'(pc_o), 2);
    chk("loop_pwm", int'(pwm_value_o), 0);
    repeat (12) begin
      global_counter_i += 20'd1;
      tick(1);
    end
    tick(6);
    chk("loop_exit_pwm", int'(pwm_value_o), 7);
    // equality against the upper slice, forward branch, right shift and oversize shift
    clear_mem();
    global_counter_i = 20'h01C05;
    do_reset();
    mem[0] = enc(1, 2, 7);
    mem[1] = enc(5, 2, 5);
    mem[2] = encj(6, 2);
    mem[3] = enc(1, 0, 1);
    mem[4] = enc(1, 0, 12);
    mem[5] = enc(3, 0, 2);
    mem[6] = enc(3, 0, 31);
    pulse_start();
    tick(3);
    chk("eq_branch_pc", int'(pc_o), 4);
    tick(2);
    chk("shr2", int'(pwm_value_o), 3);
    tick(1);
    chk("shl_big", int'(pwm_value_o), 0);
    // WAIT then HALT
    clear_mem();
    do_reset();
    mem[3] = enc(0, 0, 1);
    mem[4] = enc(1, 0, 9);
    mem[5] = enc(0, 0, 2);
    pulse_start();
    tick(4);
    chk("wait_pc", int'(pc_o), 4);
    chk("wait_busy", int'(busy_o), 0);
    tick(3);
    chk("wait_hold", int'(pc_o), 4);
    pulse_start();
    tick(2);
    chk("halt_flag", int'(halted_o), 1);
    chk("halt_pc", int'(pc_o), 6);
    chk("halt_pwm", int'(pwm_value_o), 9);
    tick(3);
    chk("halt_hold", int'(pc_o), 6);
    pulse_start();
    chk("restart_pc", int'(pc_o), 0);
    chk("restart_halted", int'(halted_o), 0);
    chk("restart_busy", int'(busy_o), 1);
    // illegal target and illegal CTRL subcode
    clear_mem();
    do_reset();
    mem[0] = enc(1, 1, 3);
    mem[1] = enc(1, 3, 9);
    mem[3] = enc(0, 0, 7);
    mem[4] = enc(1, 0, 1);
    pulse_start();
    tick(2);
    chk("ill_t_pulse", int'(illegal_o), 1);
    chk("ill_t_pc", int'(pc_o), 2);
    chk("ill_t_pwm", int'(pwm_value_o), 0);
    tick(1);
    chk("ill_t_clear", int'(illegal_o), 0);
    tick(1);
    chk("ill_ctrl_pulse", int'(illegal_o), 1);
    tick(1);
    chk("ill_ctrl_clear", int'(illegal_o), 0);
    chk("after_ill_pwm", int'(pwm_value_o), 1);
    // opcode 7
    clear_mem();
    do_reset();
`ifdef PPWM_EX_LOOP_EN
    mem[0] = encl(3, 0);
    mem[1] = enc(2, 0, 1);
    mem[2] = encl(-1, 1);
    pulse_start();
    tick(9);
    chk("lp_pwm", int'(pwm_value_o), 4);
    chk("lp_pc", int'(pc_o), 3);
    chk("lp_lc", int'(dut.lc_q), 0);
`else
    mem[0] = encl(3, 0);
    pulse_start();
    tick(1);
    chk("op7_ill", int'(illegal_o), 1);
    chk("op7_pc", int'(pc_o), 1);
`endif
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
